// File: rtl/seq_pkg.sv
// Shared constants and the transport state type for the pattern step sequencer.
package seq_pkg;

    localparam int DEF_STEPS  = 16;
    localparam int DEF_TRACKS = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level that is already synchronous to clk.
// rise is combinational: high in the cycle where d is 1 and was 0 on the previous edge.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/step_sequencer.sv
// Pattern step sequencer: advances on each rising tempo edge and fires one-cycle
// triggers for every track whose pattern bit is set at the newly entered step.
module step_sequencer
    import seq_pkg::*;
#(
    parameter  int STEPS  = DEF_STEPS,
    parameter  int TRACKS = DEF_TRACKS,
    localparam int STEP_W = $clog2(STEPS),
    localparam int TRK_W  = (TRACKS > 1) ? $clog2(TRACKS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_in,
    input  logic              play,
    input  logic              stop,
    input  logic              wr_en,
    input  logic [TRK_W-1:0]  wr_track,
    input  logic [STEP_W-1:0] wr_step,
    input  logic              wr_val,
    output logic [TRACKS-1:0] trig,
    output logic [STEP_W-1:0] step_idx,
    output logic              running
);

    seq_state_e        state_q, state_n;
    logic [STEP_W-1:0] step_q, step_n;
    logic [TRACKS-1:0] trig_q, trig_n;
    logic              running_q;
    logic              fire;
    logic              rise;

    logic [STEPS-1:0]  pattern [TRACKS];

    rise_detect u_tick_rise (
        .clk  (clk),
        .rst  (rst),
        .d    (tick_in),
        .rise (rise)
    );

    // stop beats play; play restarts and swallows a coincident rise.
    always_comb begin
        state_n = state_q;
        step_n  = step_q;
        fire    = 1'b0;
        trig_n  = '0;
        if (stop) begin
            state_n = IDLE;
            step_n  = '0;
        end else if (play) begin
            state_n = RUN;
            step_n  = '0;
            fire    = 1'b1;
        end else if ((state_q == RUN) && rise) begin
            step_n = step_q + STEP_W'(1);
            fire   = 1'b1;
        end
        // Reads the pattern before this edge's write lands, so a same-step write shows next visit.
        for (int t = 0; t < TRACKS; t++) begin
            trig_n[t] = fire & pattern[t][step_n];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            step_q    <= '0;
            trig_q    <= '0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            step_q    <= step_n;
            trig_q    <= trig_n;
            running_q <= (state_n == RUN);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < TRACKS; t++) begin
                pattern[t] <= '0;
            end
        end else if (wr_en && (32'(wr_track) < 32'(TRACKS))) begin
            pattern[wr_track][wr_step] <= wr_val;
        end
    end

    assign trig     = trig_q;
    assign step_idx = step_q;
    assign running  = running_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: table vectors for idle/write/play, then
// hand-written multi-cycle sequences for stepping, wrap, priority, collision and reset.
module tb_step_sequencer;

    logic       clk;
    logic       rst;
    logic       tick_in;
    logic       play;
    logic       stop;
    logic       wr_en;
    logic [1:0] wr_track;
    logic [3:0] wr_step;
    logic       wr_val;
    logic [3:0] trig;
    logic [3:0] step_idx;
    logic       running;

    int checks = 0;
    int errors = 0;

    // Hand-entered pattern facts used to build expected trigger columns.
    bit m_t2    = 0;
    bit m_t3    = 0;
    bit m_clear = 0;

    logic [3:0] exp_q [$];

    typedef struct {
        logic       tick;
        logic       play;
        logic       stop;
        logic       wr_en;
        logic [1:0] wr_track;
        logic [3:0] wr_step;
        logic       wr_val;
        logic [3:0] e_trig;
        logic [3:0] e_step;
        logic       e_run;
    } vec_t;

    vec_t vecs [12];

    step_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .tick_in  (tick_in),
        .play     (play),
        .stop     (stop),
        .wr_en    (wr_en),
        .wr_track (wr_track),
        .wr_step  (wr_step),
        .wr_val   (wr_val),
        .trig     (trig),
        .step_idx (step_idx),
        .running  (running)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Track 0 fires on multiples of 4, track 1 on step 2, plus the optional bits.
    function automatic logic [3:0] col(input int s);
        logic [3:0] c;
        c    = '0;
        c[0] = (s % 4 == 0);
        c[1] = (s == 2);
        c[2] = m_t2 && (s == 5);
        c[3] = m_t3 && (s == 9);
        if (m_clear) c = '0;
        return c;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        play     = 1'b0;
        stop     = 1'b0;
        wr_en    = 1'b0;
        wr_track = '0;
        wr_step  = '0;
        wr_val   = 1'b0;
    endtask

    // One full tempo period (4 high, 4 low); trigger expected only in the first high cycle.
    task automatic rise_period(input int s, input logic [3:0] et, input logic er);
        logic [3:0] es;
        es = 4'(s);
        tick_in = 1'b1;
        cyc();
        check("rise_step", 32'(step_idx), 32'(es));
        check("rise_trig", 32'(trig), 32'(et));
        check("rise_run", 32'(running), 32'(er));
        for (int i = 0; i < 7; i++) begin
            if (i == 3) tick_in = 1'b0;
            cyc();
            check("hold_trig", 32'(trig), 32'd0);
            check("hold_step", 32'(step_idx), 32'(es));
        end
    endtask

    initial begin
        rst     = 1'b1;
        tick_in = 1'b0;
        idle_inputs();

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 4'h0, 4'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 4'h0, 4'd0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 4'h0, 4'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 4'h0, 4'd0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0,  1'b1, 4'h0, 4'd0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd4,  1'b1, 4'h0, 4'd0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd8,  1'b1, 4'h0, 4'd0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd12, 1'b1, 4'h0, 4'd0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'd2,  1'b1, 4'h0, 4'd0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 4'h0, 4'd0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 4'h1, 4'd0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0,  1'b0, 4'h0, 4'd0, 1'b1};

        for (int n = 1; n <= 20; n++) exp_q.push_back(col(n % 16));

        // reset state
        #2;
        check("rst_trig", 32'(trig), 32'd0);
        check("rst_step", 32'(step_idx), 32'd0);
        check("rst_run", 32'(running), 32'd0);
        cyc();
        cyc();
        rst = 1'b0;

        // idle toggles, pattern writes, play
        for (int i = 0; i < 12; i++) begin
            tick_in  = vecs[i].tick;
            play     = vecs[i].play;
            stop     = vecs[i].stop;
            wr_en    = vecs[i].wr_en;
            wr_track = vecs[i].wr_track;
            wr_step  = vecs[i].wr_step;
            wr_val   = vecs[i].wr_val;
            cyc();
            check($sformatf("vec%0d_trig", i), 32'(trig), 32'(vecs[i].e_trig));
            check($sformatf("vec%0d_step", i), 32'(step_idx), 32'(vecs[i].e_step));
            check($sformatf("vec%0d_run", i), 32'(running), 32'(vecs[i].e_run));
        end
        idle_inputs();

        // 20 rises through the loop and past the wrap
        for (int n = 1; n <= 20; n++) begin
            rise_period(n % 16, exp_q.pop_front(), 1'b1);
        end

        // reach step 15 then wrap to 0
        for (int n = 5; n <= 15; n++) rise_period(n, col(n), 1'b1);
        rise_period(0, 4'h1, 1'b1);

        // stop+play together at step 7
        for (int n = 1; n <= 7; n++) rise_period(n, col(n), 1'b1);
        play = 1'b1;
        stop = 1'b1;
        cyc();
        check("stopplay_step", 32'(step_idx), 32'd0);
        check("stopplay_trig", 32'(trig), 32'd0);
        check("stopplay_run", 32'(running), 32'd0);
        idle_inputs();
        cyc();
        // play coincident with a rise: single restart, no double advance
        tick_in = 1'b1;
        play    = 1'b1;
        cyc();
        check("play_rise_step", 32'(step_idx), 32'd0);
        check("play_rise_trig", 32'(trig), 32'h1);
        check("play_rise_run", 32'(running), 32'd1);
        play = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) tick_in = 1'b0;
            cyc();
            check("play_hold_trig", 32'(trig), 32'd0);
            check("play_hold_step", 32'(step_idx), 32'd0);
        end

        // write into the step being entered: old value drives trig
        for (int n = 1; n <= 4; n++) rise_period(n, col(n), 1'b1);
        tick_in  = 1'b1;
        wr_en    = 1'b1;
        wr_track = 2'd2;
        wr_step  = 4'd5;
        wr_val   = 1'b1;
        cyc();
        check("coll_step", 32'(step_idx), 32'd5);
        check("coll_trig", 32'(trig), 32'h0);
        idle_inputs();
        for (int i = 0; i < 7; i++) begin
            if (i == 3) tick_in = 1'b0;
            cyc();
            check("coll_hold_trig", 32'(trig), 32'd0);
        end
        m_t2 = 1;
        for (int n = 6; n <= 21; n++) rise_period(n % 16, col(n % 16), 1'b1);

        // async reset at step 9 with a trigger in flight
        for (int n = 6; n <= 8; n++) rise_period(n, col(n), 1'b1);
        wr_en    = 1'b1;
        wr_track = 2'd3;
        wr_step  = 4'd9;
        wr_val   = 1'b1;
        cyc();
        idle_inputs();
        m_t3 = 1;
        tick_in = 1'b1;
        cyc();
        check("pre_rst_step", 32'(step_idx), 32'd9);
        check("pre_rst_trig", 32'(trig), 32'h8);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_step", 32'(step_idx), 32'd0);
        check("async_rst_trig", 32'(trig), 32'd0);
        check("async_rst_run", 32'(running), 32'd0);
        cyc();
        rst = 1'b0;
        m_clear = 1;
        // tick still high with cleared history: a rise that IDLE must ignore
        cyc();
        check("post_rst_trig", 32'(trig), 32'd0);
        check("post_rst_step", 32'(step_idx), 32'd0);
        check("post_rst_run", 32'(running), 32'd0);
        tick_in = 1'b0;
        cyc();
        play = 1'b1;
        cyc();
        play = 1'b0;
        check("replay_trig", 32'(trig), 32'd0);
        check("replay_run", 32'(running), 32'd1);
        for (int n = 1; n <= 16; n++) rise_period(n % 16, col(n % 16), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
